// File: rtl/axi_pkg.sv
// Shared AXI definitions for the write (and read) slave.
// Burst/response encodings, write FSM states, lane widths.
package axi_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_DATA = 2'b01,
        S_RESP = 2'b10
    } wstate_e;

    // WRAP bursts only allow 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) ||
               (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Next beat address and active byte lanes for an AXI burst.
// Purely combinational; shared between read and write slaves.
module axi_addr_gen
    import axi_pkg::*;
#(
    parameter int buswidth = 32
) (
    input  logic [buswidth-1:0] i_cur_addr,
    input  logic [1:0]          i_size,
    input  logic [3:0]          i_len,
    input  logic [1:0]          i_burst,
    output logic [buswidth-1:0] o_next_addr,
    output logic [LANES-1:0]    o_lane_mask
);

    localparam logic [buswidth-1:0] ONE = buswidth'(1);

    logic [buswidth-1:0] w_step;
    logic [buswidth-1:0] w_inc;
    logic [buswidth-1:0] w_wmask;

    assign w_step  = ONE << i_size;
    assign w_inc   = i_cur_addr + w_step;
    // Wrap block spans (len+1) beats of (1<<size) bytes.
    assign w_wmask = ((buswidth'(i_len) + ONE) << i_size) - ONE;

    // Address advance by burst type.
    always_comb begin
        o_next_addr = i_cur_addr;
        case (i_burst)
            BURST_INCR: o_next_addr = w_inc;
            BURST_WRAP: o_next_addr = (i_cur_addr & ~w_wmask)
                                    | (w_inc & w_wmask);
            default:    o_next_addr = i_cur_addr;
        endcase
    end

    // Lanes covered by a beat of the given size at this address.
    always_comb begin
        o_lane_mask = '1;
        case (i_size)
            2'd0:    o_lane_mask = 4'b0001 << i_cur_addr[1:0];
            2'd1:    o_lane_mask = i_cur_addr[1] ? 4'b1100 : 4'b0011;
            default: o_lane_mask = '1;
        endcase
    end

endmodule

// File: rtl/axi_write_slave.sv
// AXI3 write slave: one burst at a time, byte-enabled writes
// into a word-port memory, one B response per burst.
module axi_write_slave
    import axi_pkg::*;
#(
    parameter int buswidth     = 32,
    parameter int tagbits      = 1,
    parameter int memaddrwidth = 7
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [tagbits-1:0]      AWID,
    input  logic [buswidth-1:0]     AWADDR,
    input  logic [3:0]              AWLEN,
    input  logic [1:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic [1:0]              AWLOCK,
    input  logic [3:0]              AWCACHE,
    input  logic [2:0]              AWPROT,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [tagbits-1:0]      WID,
    input  logic [buswidth-1:0]     WDATA,
    input  logic [3:0]              WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [tagbits-1:0]      BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic [memaddrwidth-1:0] mem_addr,
    output logic [buswidth-1:0]     mem_wdata,
    output logic [3:0]              mem_wstrb,
    output logic                    memwrite
);

    localparam logic [buswidth-1:0] ONE = buswidth'(1);

    wstate_e r_state;
    wstate_e w_next_state;

    logic [tagbits-1:0]      r_id;
    logic [buswidth-1:0]     r_cur_addr;
    logic [3:0]              r_len;
    logic [1:0]              r_size;
    logic [1:0]              r_burst;
    logic [3:0]              r_count;
    logic                    r_err;

    logic                    r_awready;
    logic                    r_wready;
    logic                    r_bvalid;
    logic [tagbits-1:0]      r_bid;
    logic [1:0]              r_bresp;
    logic [memaddrwidth-1:0] r_mem_addr;
    logic [buswidth-1:0]     r_mem_wdata;
    logic [3:0]              r_mem_wstrb;
    logic                    r_memwrite;

    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_last;
    logic                    w_beat_err;
    logic                    w_misalign;
    logic                    w_aw_err;
    logic [buswidth-1:0]     w_next_addr;
    logic [LANES-1:0]        w_lane_mask;
    logic                    w_unused;

    assign w_unused = ^{AWLOCK, AWCACHE, AWPROT};

    axi_addr_gen #(
        .buswidth    (buswidth)
    ) u_addr_gen (
        .i_cur_addr  (r_cur_addr),
        .i_size      (r_size),
        .i_len       (r_len),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr),
        .o_lane_mask (w_lane_mask)
    );

    assign w_aw_hs    = AWVALID & r_awready;
    assign w_w_hs     = WVALID & r_wready;
    assign w_last     = (r_count == r_len);
    assign w_beat_err = (WID != r_id) | (WLAST != w_last);
    assign w_misalign = (AWADDR & ((ONE << AWSIZE) - ONE)) != '0;
    assign w_aw_err   = (AWBURST == BURST_RSVD) | (AWSIZE == 2'b11)
                      | ((AWBURST == BURST_WRAP)
                         & (~wrap_len_ok(AWLEN) | w_misalign));

    // Next-state logic; the beat count, not WLAST, ends a burst.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: if (w_aw_hs) w_next_state = S_DATA;
            S_DATA: if (w_w_hs && w_last) w_next_state = S_RESP;
            S_RESP: if (r_bvalid && BREADY) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Handshake outputs follow the next state so they are registered.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_awready <= (w_next_state == S_IDLE);
            r_wready  <= (w_next_state == S_DATA);
            r_bvalid  <= (w_next_state == S_RESP);
        end
    end

    // Burst context, memory write port and response fields.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_id        <= '0;
            r_cur_addr  <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_bid       <= '0;
            r_bresp     <= RESP_OKAY;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_memwrite  <= 1'b0;
        end else begin
            r_memwrite <= 1'b0;
            if (w_aw_hs) begin
                r_id       <= AWID;
                r_cur_addr <= AWADDR;
                r_len      <= AWLEN;
                r_size     <= AWSIZE;
                r_burst    <= AWBURST;
                r_count    <= '0;
                r_err      <= w_aw_err;
            end
            if (w_w_hs) begin
                // The offending beat and all later ones are dropped.
                if (!r_err && !w_beat_err) begin
                    r_memwrite  <= 1'b1;
                    r_mem_addr  <= {r_cur_addr[memaddrwidth-1:2], 2'b00};
                    r_mem_wdata <= WDATA;
                    r_mem_wstrb <= WSTRB & w_lane_mask;
                end
                r_err      <= r_err | w_beat_err;
                r_cur_addr <= w_next_addr;
                r_count    <= r_count + 4'd1;
                if (w_last) begin
                    r_bid   <= r_id;
                    r_bresp <= (r_err | w_beat_err) ? RESP_SLVERR
                                                    : RESP_OKAY;
                end
            end
        end
    end

    assign AWREADY   = r_awready;
    assign WREADY    = r_wready;
    assign BVALID    = r_bvalid;
    assign BID       = r_bid;
    assign BRESP     = r_bresp;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign memwrite  = r_memwrite;

endmodule

// File: tb/tb_axi_write_slave.sv
// Directed self-checking bench for axi_write_slave.
// Inputs driven and outputs sampled on the falling edge.
module tb_axi_write_slave;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [1:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic [1:0]  AWLOCK;
    logic [3:0]  AWCACHE;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic        WID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic        BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        memwrite;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0]  q_addr[$];
    logic [3:0]  q_strb[$];
    logic [31:0] q_data[$];

    axi_write_slave dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .AWID      (AWID),
        .AWADDR    (AWADDR),
        .AWLEN     (AWLEN),
        .AWSIZE    (AWSIZE),
        .AWBURST   (AWBURST),
        .AWLOCK    (AWLOCK),
        .AWCACHE   (AWCACHE),
        .AWPROT    (AWPROT),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WID       (WID),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WLAST     (WLAST),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BID       (BID),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .memwrite  (memwrite)
    );

    always #5 ACLK = ~ACLK;

    // Record every memory write strobe seen by the memory side.
    always @(negedge ACLK) begin
        if (memwrite === 1'b1) begin
            q_addr.push_back(mem_addr);
            q_strb.push_back(mem_wstrb);
            q_data.push_back(mem_wdata);
        end
    end

    task automatic clear_log();
        q_addr.delete();
        q_strb.delete();
        q_data.delete();
    endtask

    // Drive one AW and the W beats; abort_at stops with WVALID high.
    task automatic run_burst(input logic id, input logic [31:0] addr,
                             input logic [3:0] len, input logic [1:0] size,
                             input logic [1:0] burst, input logic [31:0] dbase,
                             input int last_at, input int gap,
                             input int abort_at);
        int t;
        AWID = id; AWADDR = addr; AWLEN = len;
        AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        t = 0;
        while (AWREADY !== 1'b1 && t < 50) begin
            @(negedge ACLK); t++;
        end
        if (t >= 50) begin
            n_tests++; n_fail++;
            $display("FAIL aw_timeout got AWREADY=%b required 1", AWREADY);
        end
        @(negedge ACLK);
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (gap > 0 && i > 0) repeat (gap) @(negedge ACLK);
            WID = id;
            WDATA = dbase + 32'(i) * 32'h01010101;
            WSTRB = 4'hF;
            WLAST = (i == last_at);
            WVALID = 1'b1;
            if (i == abort_at) return;
            t = 0;
            while (WREADY !== 1'b1 && t < 50) begin
                @(negedge ACLK); t++;
            end
            if (t >= 50) begin
                n_tests++; n_fail++;
                $display("FAIL w_timeout beat %0d got WREADY=%b required 1",
                         i, WREADY);
            end
            @(negedge ACLK);
            WVALID = 1'b0;
            WLAST = 1'b0;
        end
    endtask

    // Wait for BVALID, capture the response, handshake it.
    task automatic wait_b(output logic id, output logic [1:0] resp,
                          output logic seen);
        int t;
        t = 0;
        while (BVALID !== 1'b1 && t < 50) begin
            @(negedge ACLK); t++;
        end
        seen = (BVALID === 1'b1);
        id = BID;
        resp = BRESP;
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge ACLK);
        @(negedge ACLK);
        n_tests++;
        if ({AWREADY, WREADY, BVALID, BID, BRESP, memwrite} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b required 0000000",
                     {AWREADY, WREADY, BVALID, BID, BRESP, memwrite});
        end
        n_tests++;
        if ({mem_addr, mem_wdata, mem_wstrb} !== 43'b0) begin
            n_fail++;
            $display("FAIL reset_mem got %h required 0",
                     {mem_addr, mem_wdata, mem_wstrb});
        end
        ARESET = 1'b0;
        #1;
        n_tests++;
        if (AWREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_awready got %b required 0", AWREADY);
        end
        @(negedge ACLK);
        n_tests++;
        if (AWREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_edge_awready got %b required 1",
                     AWREADY);
        end
    endtask

    task automatic test_incr_word();
        logic id; logic [1:0] rs; logic seen;
        clear_log();
        run_burst(1'b0, 32'h00, 4'd3, 2'd2, 2'b01, 32'hA0A0A0A0, 3, 0, -1);
        n_tests++;
        if ({BVALID, memwrite} !== 2'b11) begin
            n_fail++;
            $display("FAIL incr_word_b_timing got %b required 11",
                     {BVALID, memwrite});
        end
        wait_b(id, rs, seen);
        n_tests++;
        if ({seen, id, rs} !== 4'b1000) begin
            n_fail++;
            $display("FAIL incr_word_b got %b required 1000", {seen, id, rs});
        end
        n_tests++;
        if (q_addr.size() != 4) begin
            n_fail++;
            $display("FAIL incr_word_count got %0d required 4", q_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if ({q_addr[i], q_strb[i], q_data[i]} !==
                    {7'(4 * i), 4'hF, 32'hA0A0A0A0 + 32'(i) * 32'h01010101})
                begin
                    n_fail++;
                    $display("FAIL incr_word_beat%0d got %h/%b/%h", i,
                             q_addr[i], q_strb[i], q_data[i]);
                end
            end
        end
    endtask

    task automatic test_incr_byte();
        logic id; logic [1:0] rs; logic seen;
        logic [3:0] es [3] = '{4'b0010, 4'b0100, 4'b1000};
        clear_log();
        run_burst(1'b1, 32'h09, 4'd2, 2'd0, 2'b01, 32'h11223344, 2, 0, -1);
        wait_b(id, rs, seen);
        n_tests++;
        if ({seen, id, rs} !== 4'b1100) begin
            n_fail++;
            $display("FAIL incr_byte_b got %b required 1100", {seen, id, rs});
        end
        n_tests++;
        if (q_addr.size() != 3) begin
            n_fail++;
            $display("FAIL incr_byte_count got %0d required 3", q_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if ({q_addr[i], q_strb[i]} !== {7'h08, es[i]}) begin
                    n_fail++;
                    $display("FAIL incr_byte_beat%0d got %h/%b required 08/%b",
                             i, q_addr[i], q_strb[i], es[i]);
                end
            end
        end
    endtask

    task automatic test_wrap_fixed();
        logic id; logic [1:0] rs; logic seen;
        logic [6:0] ew [4] = '{7'h18, 7'h1C, 7'h10, 7'h14};
        clear_log();
        run_burst(1'b0, 32'h18, 4'd3, 2'd2, 2'b10, 32'h55000000, 3, 0, -1);
        wait_b(id, rs, seen);
        n_tests++;
        if ({seen, rs} !== 3'b100) begin
            n_fail++;
            $display("FAIL wrap_b got %b required 100", {seen, rs});
        end
        n_tests++;
        if (q_addr.size() != 4) begin
            n_fail++;
            $display("FAIL wrap_count got %0d required 4", q_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (q_addr[i] !== ew[i]) begin
                    n_fail++;
                    $display("FAIL wrap_addr%0d got %h required %h",
                             i, q_addr[i], ew[i]);
                end
            end
        end
        clear_log();
        run_burst(1'b0, 32'h20, 4'd1, 2'd2, 2'b00, 32'h66000000, 1, 0, -1);
        wait_b(id, rs, seen);
        n_tests++;
        if ({seen, rs} !== 3'b100) begin
            n_fail++;
            $display("FAIL fixed_b got %b required 100", {seen, rs});
        end
        n_tests++;
        if (q_addr.size() != 2 || q_addr[0] !== 7'h20 || q_addr[1] !== 7'h20)
        begin
            n_fail++;
            $display("FAIL fixed_addr got n=%0d required 2 writes at 20",
                     q_addr.size());
        end
    endtask

    task automatic test_errors();
        logic id; logic [1:0] rs; logic seen;
        clear_log();
        run_burst(1'b0, 32'h40, 4'd3, 2'd2, 2'b01, 32'h77000000, 1, 0, -1);
        n_tests++;
        if ({BVALID, memwrite} !== 2'b10) begin
            n_fail++;
            $display("FAIL wlast_err_b_timing got %b required 10",
                     {BVALID, memwrite});
        end
        wait_b(id, rs, seen);
        n_tests++;
        if ({seen, rs} !== 3'b110) begin
            n_fail++;
            $display("FAIL wlast_err_b got %b required 110", {seen, rs});
        end
        n_tests++;
        if (q_addr.size() != 1 || q_addr[0] !== 7'h40) begin
            n_fail++;
            $display("FAIL wlast_err_writes got n=%0d required 1 at 40",
                     q_addr.size());
        end
        clear_log();
        run_burst(1'b1, 32'h00, 4'd1, 2'd2, 2'b11, 32'h88000000, 1, 0, -1);
        wait_b(id, rs, seen);
        n_tests++;
        if ({seen, id, rs} !== 4'b1110) begin
            n_fail++;
            $display("FAIL rsvd_b got %b required 1110", {seen, id, rs});
        end
        n_tests++;
        if (q_addr.size() != 0) begin
            n_fail++;
            $display("FAIL rsvd_writes got %0d required 0", q_addr.size());
        end
    endtask

    task automatic test_bready_hold();
        logic id; logic [1:0] rs; logic seen;
        clear_log();
        run_burst(1'b1, 32'h30, 4'd0, 2'd2, 2'b01, 32'h99000000, 0, 0, -1);
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if ({BVALID, BID, BRESP, AWREADY} !== 5'b11000) begin
                n_fail++;
                $display("FAIL bready_hold_c%0d got %b required 11000",
                         c, {BVALID, BID, BRESP, AWREADY});
            end
            @(negedge ACLK);
        end
        wait_b(id, rs, seen);
        n_tests++;
        if ({BVALID, AWREADY} !== 2'b01) begin
            n_fail++;
            $display("FAIL bready_release got %b required 01",
                     {BVALID, AWREADY});
        end
    endtask

    task automatic test_wvalid_gaps();
        logic id; logic [1:0] rs; logic seen;
        clear_log();
        run_burst(1'b0, 32'h50, 4'd2, 2'd2, 2'b01, 32'hAB000000, 2, 3, -1);
        wait_b(id, rs, seen);
        n_tests++;
        if ({seen, rs} !== 3'b100) begin
            n_fail++;
            $display("FAIL gaps_b got %b required 100", {seen, rs});
        end
        n_tests++;
        if (q_addr.size() != 3 || q_addr[0] !== 7'h50 ||
            q_addr[1] !== 7'h54 || q_addr[2] !== 7'h58) begin
            n_fail++;
            $display("FAIL gaps_addrs got n=%0d required 50,54,58",
                     q_addr.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        logic id; logic [1:0] rs; logic seen;
        clear_log();
        run_burst(1'b0, 32'h60, 4'd3, 2'd2, 2'b01, 32'hCD000000, 3, 0, 1);
        n_tests++;
        if ({memwrite, WREADY} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_reset_pre got %b required 11",
                     {memwrite, WREADY});
        end
        #1 ARESET = 1'b1;
        #1;
        n_tests++;
        if ({memwrite, WREADY, BVALID, AWREADY} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset_drop got %b required 0000",
                     {memwrite, WREADY, BVALID, AWREADY});
        end
        WVALID = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        n_tests++;
        if ({AWREADY, BVALID} !== 2'b10 || q_addr.size() != 1) begin
            n_fail++;
            $display("FAIL mid_reset_after got %b n=%0d required 10 n=1",
                     {AWREADY, BVALID}, q_addr.size());
        end
        run_burst(1'b1, 32'h70, 4'd1, 2'd2, 2'b01, 32'hEF000000, 1, 0, -1);
        wait_b(id, rs, seen);
        n_tests++;
        if ({seen, id, rs} !== 4'b1100) begin
            n_fail++;
            $display("FAIL mid_reset_new_b got %b required 1100",
                     {seen, id, rs});
        end
        n_tests++;
        if (q_addr.size() != 3 || q_addr[1] !== 7'h70 ||
            q_addr[2] !== 7'h74) begin
            n_fail++;
            $display("FAIL mid_reset_new_writes got n=%0d required 3",
                     q_addr.size());
        end
    endtask

    initial begin
        AWID = 1'b0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
        AWLOCK = '0; AWCACHE = '0; AWPROT = '0; AWVALID = 1'b0;
        WID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        BREADY = 1'b0;
        test_reset();
        test_incr_word();
        test_incr_byte();
        test_wrap_fixed();
        test_errors();
        test_bready_hold();
        test_wvalid_gaps();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_write_slave.md
Name: axi_write_slave

Overview:
- AXI3-style write responder for the project's AXI interconnect; the write-direction counterpart of the existing read slave.
- Accepts one write burst at a time on AW, consumes beats on W, and drives byte-enabled single-cycle writes into the 128-byte word-port memory. Returns a per-burst response on B.
- Sits between the write master and a memory exposing write address, data, byte enables and a write strobe.

Parameters:
- buswidth, 32, data/address bus width in bits (byte lanes = buswidth/8 = 4)
- tagbits, 1, width of AWID/WID/BID
- memaddrwidth, 7, width of the memory byte address

Ports:
- ACLK  in  1  single clock, all state on rising edge
- ARESET  in  1  reset, asynchronous, active-high
- AWID  in  tagbits  write transaction tag
- AWADDR  in  buswidth  burst start byte address
- AWLEN  in  4  beats minus 1
- AWSIZE  in  2  bytes per beat = 1<<AWSIZE (0..2 legal)
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- AWLOCK  in  2  accepted, ignored
- AWCACHE  in  4  accepted, ignored
- AWPROT  in  3  accepted, ignored
- AWVALID  in  1  address valid
- AWREADY  out  1  address ready
- WID  in  tagbits  data tag
- WDATA  in  buswidth  write data, lane-aligned
- WSTRB  in  4  byte strobes
- WLAST  in  1  final beat marker
- WVALID  in  1  data valid
- WREADY  out  1  data ready
- BID  out  tagbits  response tag (= latched AWID)
- BRESP  out  2  00 OKAY, 10 SLVERR
- BVALID  out  1  response valid
- BREADY  in  1  response ready
- mem_addr  out  memaddrwidth  word-aligned byte address (low 2 bits 0)
- mem_wdata  out  buswidth  write data
- mem_wstrb  out  4  byte enables
- memwrite  out  1  one-cycle write strobe

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While ARESET=1, state=IDLE and AWREADY=0, WREADY=0, BVALID=0, BRESP=00, BID=0, memwrite=0, mem_addr=0, mem_wdata=0, mem_wstrb=0. Reset asserted mid-burst aborts immediately with no further memory writes and no B response. AWREADY rises on the first rising edge after release.
- All outputs are registered.
- FSM IDLE: AWREADY=1. On AWVALID&AWREADY: latch ID, address, len, size, burst; clear beat counter and error flag; go DATA. Latency is one cycle: WREADY=1 in the next cycle. AWREADY=0 outside IDLE.
- Protocol errors set the error flag at AW accept: AWBURST=11, AWSIZE=11, WRAP with AWLEN not in {1,3,7,15}, or WRAP with AWADDR not aligned to the size.
- FSM DATA: WREADY=1.
  - On each WVALID&WREADY beat, if the error flag is clear: next cycle memwrite=1, mem_addr=cur_addr&~3, mem_wdata=WDATA, mem_wstrb=WSTRB&lane_mask.
  - lane_mask: size 0 = 1 lane at cur_addr[1:0]; size 1 = 2 lanes at cur_addr[1]; size 2 = all lanes.
  - If the error flag is set, beats are consumed and no writes are issued.
  - WID != latched ID or WLAST!=(count==len) on a beat sets the error flag for the remaining beats (earlier beats already written stand).
  - After the beat, cur_addr advances:
    - FIXED: unchanged.
    - INCR: +(1<<size), truncated to buswidth with no 4 KB check.
    - WRAP: increment inside the boundary block of (len+1)<<size bytes; wraps to the block base.
  - count increments each beat. The beat with count==len ends the burst (WLAST is not used to terminate): WREADY=0, go RESP.
- FSM RESP: BVALID=1, BID=latched ID, BRESP=SLVERR if the error flag is set else OKAY. BVALID appears the cycle after the final W handshake, coincident with the last memwrite. Hold until BREADY, then go IDLE; AWREADY=1 the next cycle. BREADY already high gives a single-cycle BVALID.
- Throughput: back-to-back bursts have 1 idle cycle minimum between B handshake and next AW accept. No outstanding-transaction overlap.
- WVALID low in DATA inserts wait states; counter and address hold.

Decomposition:
- Shared package axi_pkg:
  - burst encodings FIXED/INCR/WRAP
  - response codes OKAY/SLVERR
  - write FSM state encoding IDLE/DATA/RESP
  - lane-mask constant widths
- Sub-module axi_addr_gen: combinational next-address plus lane mask from cur_addr/size/len/burst. Reusable by the read slave.

Test Plan:
- AW{ID=0,ADDR=0x00,LEN=3,SIZE=2,INCR}, 4 beats WDATA=0xA0A0A0A0.., WSTRB=F, WLAST on beat 4 -> memwrite at 0x00,0x04,0x08,0x0C with wstrb=F; BVALID cycle after beat 4, BID=0, BRESP=00.
- AW{ID=1,ADDR=0x09,LEN=2,SIZE=0,INCR}, WSTRB=F -> mem_addr 0x08,0x08,0x08 with wstrb 0010,0100,1000; BRESP=00, BID=1.
- AW{ADDR=0x18,LEN=3,SIZE=2,WRAP} -> mem_addr 0x18,0x1C,0x10,0x14; AW{ADDR=0x20,LEN=1,FIXED} -> 0x20 twice; both OKAY.
- WLAST asserted on beat 2 of LEN=3 INCR from 0x40 -> beats 1 written only (0x40), 4 beats still consumed, BRESP=10. AWBURST=11 -> no memwrite at all, BRESP=10.
- Hold BREADY=0 for 5 cycles -> BVALID/BID/BRESP stable, AWREADY=0. Insert WVALID gaps -> addresses unchanged. Assert ARESET during beat 2 -> memwrite, WREADY and BVALID drop immediately; after release AWREADY=1 and a new burst completes OKAY.
